if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage for the five-stage MIPS core. It sits at the opposite end of the ID stage's IF-facing interface: it owns the PC and consumes the branch redirect (`branch_flag`/`branch_addr`) and the pipeline stall that ID produces. It drives a variable-latency instruction-ROM handshake and feeds the IF/ID pipeline register that supplies `addr`/`inst` to ID.

## Interface
- `RESET_PC`, default 32'hbfc0_0000: PC value loaded at reset.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-low reset; asserted when 0, sampled on `clk`.
- `stall_in` input 1: pipeline stall from pipeline control (includes ID `stall_request`). While it is 1, IF/ID holds and nothing is issued.
- `branch_flag` input 1: redirect from ID; valid only in cycles where `if_valid`=1 and `stall_in`=0.
- `branch_addr` input 32: redirect target.
- `rom_en` output 1: fetch request.
- `rom_addr` output 32: fetch address, word-aligned.
- `rom_ready` input 1: response valid. Ready may be asserted in the same cycle as the request (0-wait) or any number of cycles later.
- `rom_rdata` input 32: instruction word, valid when `rom_ready`=1.
- `if_valid` output 1: IF/ID holds a real instruction; 0 means a bubble.
- `if_addr` output 32: PC of the IF/ID instruction, to ID `addr`.
- `if_inst` output 32: instruction, to ID `inst`. It is 32'h0 (nop) when this is a bubble.

## Operation
- The FSM has three states: RESET, REQ and HOLD.
- **RESET** (entered while `rst`=0):
  - `pc`=`RESET_PC`, `rom_en`=0, `br_pending`=0.
  - IF/ID is cleared.
  - On the first cycle with `rst`=1, go to REQ.
- **REQ**:
  - `rom_en`=1 and `rom_addr`=`pc`, both held stable until `rom_ready`.
  - `rom_ready`=1, `stall_in`=0 → issue: IF/ID ← {1, `pc`, `rom_rdata`}, `pc` ← `next_pc`, stay in REQ.
  - `rom_ready`=1, `stall_in`=1 → `buf` ← `rom_rdata`, go to HOLD. `pc` is unchanged.
  - `rom_ready`=0, `stall_in`=0 → IF/ID ← bubble {0, 0, 0}.
  - `rom_ready`=0, `stall_in`=1 → IF/ID holds.
- **HOLD**:
  - `rom_en`=0; `rom_ready` is ignored.
  - When `stall_in`=0 → issue {1, `pc`, `buf`}, `pc` ← `next_pc`, go to REQ.
- **Branch capture (delay slot):**
  - `take` = `branch_flag` & `if_valid` & ~`stall_in`.
  - `next_pc` = `take` ? `branch_addr` : `br_pending` ? `br_tgt` : `pc`+4. Addition wraps modulo 2^32.
  - If `take` and no issue happens in the same cycle, then `br_pending` ← 1 and `br_tgt` ← `branch_addr`.
  - Every issue clears `br_pending`.
  - The instruction issued right after a taken branch is the delay slot at branch+4. The fetch after it is the target.
- `rom_ready` outside REQ is ignored. This covers a response left over from a fetch aborted by reset.
- Reset mid-fetch abandons the outstanding request. A pending branch is discarded.

## Timing
- Reset values: `rom_en`=0, `rom_addr`=`RESET_PC`, `if_valid`=0, `if_addr`=0, `if_inst`=0.
- Latency:
  - First request is 1 cycle after reset release.
  - With a 0-wait ROM: 1 instruction per cycle; IF/ID updates on the edge after `rom_ready`.
  - With an N-wait ROM: N bubbles per instruction.
- `take` in the same cycle as an issue uses `branch_addr` directly; no pending state is created.
- `stall_in` has priority over issue in every state. A stall never drops a fetched word (it goes to `buf`) and never re-fetches.
- `if_addr` is always word-aligned, because `branch_addr` is word-aligned by construction in ID.

## Structure
- `RESET_PC` default and the FSM state encodings go in `bus.v`, next to `ADDR_BUS`/`INST_BUS`. Use `ADDR_BUS`/`INST_BUS` for all port widths.
- One sub-module, `if_id_reg`: the IF/ID pipeline register with load, hold and bubble controls, and synchronous active-low clear.
- PC, `br_pending`/`br_tgt`, `buf` and the FSM live in `if_fetch`.

## Test plan
- 0-wait ROM, no stalls → after reset `rom_addr` steps 0xbfc00000, …04, …08 one per cycle. `if_addr` follows one cycle later with `if_valid`=1.
- 2-wait ROM → each request holds `rom_addr` 3 cycles. IF/ID shows 2 bubbles (`if_inst`=0, `if_valid`=0) between instructions.
- Branch at 0xbfc00010, `branch_addr`=0xbfc00100, 0-wait → `if_addr` sequence …10, …14 (delay slot), …100.
- Same branch, 3-wait ROM so the delay slot is still in flight when ID takes it → `br_pending` set. After …14 issues, `rom_addr`=0xbfc00100.
- `stall_in`=1 for 4 cycles while `rom_ready` pulses → word goes to `buf`, `rom_en`=0, IF/ID frozen. On release the word issues with no re-fetch.
- `rst`=0 in the middle of a 3-wait fetch at 0xbfc00020, then a stale `rom_ready` in RESET → outputs return to reset values. The first request after release is 0xbfc00000.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared widths, reset vector, FSM encodings and the IF/ID record for the fetch stage.
package if_fetch_pkg;

    localparam int ADDR_BUS = 32;
    localparam int INST_BUS = 32;

    localparam logic [ADDR_BUS-1:0] RESET_PC_DEF = 32'hbfc0_0000;

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef struct packed {
        logic                valid;
        logic [ADDR_BUS-1:0] addr;
        logic [INST_BUS-1:0] inst;
    } if_id_t;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [ADDR_BUS-1:0] pc_inc(input logic [ADDR_BUS-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Variable-latency instruction-ROM handshake: request held until ready.
interface if_fetch_if import if_fetch_pkg::*; ();

    logic                en;
    logic [ADDR_BUS-1:0] addr;
    logic                ready;
    logic [INST_BUS-1:0] rdata;

    modport master (output en, output addr, input ready, input rdata);
    modport slave  (input en, input addr, output ready, output rdata);

endinterface

// File: rtl/if_fetch_if_id_reg.sv
// IF/ID pipeline register: clear beats load, load beats bubble, otherwise hold.
module if_id_reg import if_fetch_pkg::*; (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    // Register update with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (bubble) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the ROM handshake, feeds IF/ID.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RESET | reset held or just released; no request, pc = RESET_PC
// ST_REQ   | request at pc outstanding; issue on ready unless stalled
// ST_HOLD  | word captured in inst_buf during a stall; waiting to issue it
module if_fetch import if_fetch_pkg::*; #(
    parameter logic [ADDR_BUS-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_in,
    input  logic                branch_flag,
    input  logic [ADDR_BUS-1:0] branch_addr,
    if_fetch_if.master          rom,
    output logic                if_valid,
    output logic [ADDR_BUS-1:0] if_addr,
    output logic [INST_BUS-1:0] if_inst
);

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [ADDR_BUS-1:0] pc;
    logic [ADDR_BUS-1:0] next_pc;
    logic [ADDR_BUS-1:0] br_tgt;
    logic                br_pending;
    logic [INST_BUS-1:0] inst_buf;
    logic                in_req;
    logic                in_hold;
    logic                got_word;
    logic                issue;
    logic                take;
    logic                bubble;
    if_id_t              ifid_d;
    if_id_t              ifid_q;

    // Handshake decode, issue/branch decisions and the candidate IF/ID word.
    always_comb begin
        in_req   = (state == ST_REQ);
        in_hold  = (state == ST_HOLD);
        got_word = in_req & rom.ready;
        issue    = ~stall_in & (got_word | in_hold);
        take     = branch_flag & if_valid & ~stall_in;
        bubble   = in_req & ~rom.ready & ~stall_in;
        // A branch taken alongside an issue redirects immediately; otherwise it is
        // remembered so the fetch after the delay slot goes to the target.
        next_pc  = take ? branch_addr : (br_pending ? br_tgt : pc_inc(pc));
        rom.en   = in_req;
        rom.addr = pc;
        ifid_d.valid = 1'b1;
        ifid_d.addr  = pc;
        ifid_d.inst  = in_hold ? inst_buf : rom.rdata;
    end

    // Next-state selection; a stalled response parks the word in HOLD.
    always_comb begin
        state_nxt = ST_RESET;
        case (state)
            ST_RESET: state_nxt = ST_REQ;
            ST_REQ:   state_nxt = (got_word & stall_in) ? ST_HOLD : ST_REQ;
            ST_HOLD:  state_nxt = stall_in ? ST_HOLD : ST_REQ;
            default:  state_nxt = ST_RESET;
        endcase
    end

    // FSM, PC, pending-branch and stall-buffer state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_RESET;
            pc         <= RESET_PC;
            br_pending <= 1'b0;
            br_tgt     <= '0;
            inst_buf   <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                pc         <= next_pc;
                br_pending <= 1'b0;
            end else if (take) begin
                br_pending <= 1'b1;
                br_tgt     <= branch_addr;
            end
            if (got_word & stall_in) begin
                inst_buf <= rom.rdata;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (issue),
        .bubble (bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign if_valid = ifid_q.valid;
    assign if_addr  = ifid_q.addr;
    assign if_inst  = ifid_q.inst;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus randomized traffic
// against a transaction-level model of the fetch stream.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [31:0] RPC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_in = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        if_valid;
    logic [31:0] if_addr;
    logic [31:0] if_inst;

    if_fetch_if rom_bus ();

    if_fetch #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_in    (stall_in),
        .branch_flag (branch_flag),
        .branch_addr (branch_addr),
        .rom         (rom_bus),
        .if_valid    (if_valid),
        .if_addr     (if_addr),
        .if_inst     (if_inst)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // stimulus knobs
    int          lat_k = 0;
    int          stall_pct = 0;
    int          stray_pct = 0;
    int          br_mode = 0;
    bit          stall_force = 0;
    bit          rst_k = 0;
    logic [31:0] br_at = 32'hbfc0_0010;
    logic [31:0] br_to = 32'hbfc0_0100;

    logic [31:0] iss_q[$];
    int          iss_cyc[$];
    logic [31:0] exp_q[$];
    logic [31:0] rom_after_ds = '0;
    int          cyc = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'ha5a5_0f0f;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    initial begin
        rom_bus.ready = 1'b0;
        rom_bus.rdata = '0;
    end

    // ROM responder, stall and ID-side branch driver (applied 1 time unit after each rising edge)
    bit req_active = 0;
    int wait_left = 0;
    always @(posedge clk) begin
        #1;
        rst = rst_k;
        stall_in = stall_force | (int'($urandom_range(99)) < stall_pct);
        rom_bus.ready = 1'b0;
        rom_bus.rdata = $urandom;
        if (rom_bus.en) begin
            if (!req_active) begin
                req_active = 1;
                wait_left = (lat_k < 0) ? int'($urandom_range(3)) : lat_k;
            end
            if (wait_left == 0) begin
                rom_bus.ready = 1'b1;
                rom_bus.rdata = word_of(rom_bus.addr);
                req_active = 0;
            end else begin
                wait_left--;
            end
        end else begin
            req_active = 0;
            if (int'($urandom_range(99)) < stray_pct) rom_bus.ready = 1'b1;
        end
        branch_flag = 1'b0;
        branch_addr = $urandom & 32'hffff_fffc;
        if (if_valid) begin
            if (br_mode == 1 && if_addr == br_at) begin
                branch_flag = 1'b1;
                branch_addr = br_to;
            end else if (br_mode == 2 && $urandom_range(3) == 0) begin
                branch_flag = 1'b1;
                branch_addr = RPC | (32'($urandom_range(255)) << 2);
            end
        end
    end

    // Reference model: the fetch stream as a sequence of issue events
    logic        m_valid = 0;
    logic [31:0] m_addr = '0, m_inst = '0, m_fetch = RPC, m_tgt = '0, m_buf = '0;
    bit          m_pend = 0, m_full = 0, m_live = 0, m_issued = 0;
    always @(posedge clk) begin
        bit got;
        bit take;
        logic [31:0] nxt;
        cyc++;
        m_issued = 0;
        if (!rst) begin
            m_valid = 0; m_addr = '0; m_inst = '0; m_fetch = RPC;
            m_pend = 0; m_full = 0; m_live = 0;
        end else begin
            got  = m_live && !m_full && rom_bus.ready;
            take = branch_flag && m_valid && !stall_in;
            nxt  = take ? branch_addr : (m_pend ? m_tgt : m_fetch + 32'd4);
            if (stall_in) begin
                if (got) begin
                    m_full = 1;
                    m_buf  = rom_bus.rdata;
                end
            end else if (got || m_full) begin
                m_valid = 1;
                m_addr  = m_fetch;
                m_inst  = m_full ? m_buf : rom_bus.rdata;
                m_fetch = nxt;
                m_pend  = 0;
                m_full  = 0;
                m_issued = 1;
            end else begin
                m_valid = 0; m_addr = '0; m_inst = '0;
                if (take) begin
                    m_pend = 1;
                    m_tgt  = branch_addr;
                end
            end
            m_live = 1;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        chk("if_addr", if_addr, m_addr);
        chk("if_inst", if_inst, m_inst);
        chk("rom_en", {31'd0, rom_bus.en}, {31'd0, (m_live && !m_full)});
        if (m_live && !m_full) chk("rom_addr", rom_bus.addr, m_fetch);
        if (if_valid) chk("inst_content", if_inst, word_of(if_addr));
        if (m_issued) begin
            iss_q.push_back(if_addr);
            iss_cyc.push_back(cyc);
            if (if_addr == 32'hbfc0_0014) rom_after_ds = rom_bus.addr;
        end
    end

    task automatic restart();
        rst_k = 0;
        repeat (3) @(posedge clk);
        rst_k = 1;
        iss_q.delete();
        iss_cyc.delete();
    endtask

    task automatic check_seq(input string tag);
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_seq%0d", tag, i), (i < iss_q.size()) ? iss_q[i] : 32'hxxxx_xxxx, exp_q[i]);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rom_en"}, {31'd0, rom_bus.en}, 32'd0);
        chk({tag, "_rom_addr"}, rom_bus.addr, RPC);
        chk({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_if_addr"}, if_addr, 32'd0);
        chk({tag, "_if_inst"}, if_inst, 32'd0);
    endtask

    initial begin
        bit found;

        // 0-wait ROM, branch at ...10 to ...100 taken alongside the delay-slot issue
        br_mode = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        rst_k = 1;
        @(negedge clk);
        chk("first_req_delay", {31'd0, rom_bus.en}, 32'd0);
        @(negedge clk);
        chk("first_req_en", {31'd0, rom_bus.en}, 32'd1);
        chk("first_req_addr", rom_bus.addr, 32'hbfc0_0000);
        @(negedge clk);
        chk("w0_rom_addr1", rom_bus.addr, 32'hbfc0_0004);
        chk("w0_if_addr0", if_addr, 32'hbfc0_0000);
        chk("w0_if_valid", {31'd0, if_valid}, 32'd1);
        @(negedge clk);
        chk("w0_rom_addr2", rom_bus.addr, 32'hbfc0_0008);
        chk("w0_if_addr1", if_addr, 32'hbfc0_0004);
        repeat (8) @(posedge clk);
        exp_q = '{32'hbfc0_0000, 32'hbfc0_0004, 32'hbfc0_0008, 32'hbfc0_000c,
                  32'hbfc0_0010, 32'hbfc0_0014, 32'hbfc0_0100, 32'hbfc0_0104};
        check_seq("br0wait");

        // 2-wait ROM: three cycles per instruction
        lat_k = 2; br_mode = 0;
        restart();
        repeat (20) @(posedge clk);
        exp_q = '{32'hbfc0_0000, 32'hbfc0_0004, 32'hbfc0_0008, 32'hbfc0_000c};
        check_seq("wait2");
        chk("wait2_gap1", (iss_cyc.size() >= 4) ? 32'(iss_cyc[2] - iss_cyc[1]) : 32'hffff_ffff, 32'd3);
        chk("wait2_gap2", (iss_cyc.size() >= 4) ? 32'(iss_cyc[3] - iss_cyc[2]) : 32'hffff_ffff, 32'd3);

        // 3-wait ROM: branch taken while delay slot is in flight leaves a pending target
        lat_k = 3; br_mode = 1; rom_after_ds = '0;
        restart();
        repeat (50) @(posedge clk);
        exp_q = '{32'hbfc0_0000, 32'hbfc0_0004, 32'hbfc0_0008, 32'hbfc0_000c,
                  32'hbfc0_0010, 32'hbfc0_0014, 32'hbfc0_0100, 32'hbfc0_0104};
        check_seq("pend");
        chk("pend_fetch_after_ds", rom_after_ds, 32'hbfc0_0100);

        // 4-cycle stall with a 0-wait ROM: word parked, no re-fetch
        lat_k = 0; br_mode = 0;
        restart();
        repeat (4) @(posedge clk);
        stall_force = 1;
        @(negedge clk);
        chk("stall_first_en", {31'd0, rom_bus.en}, 32'd1);
        chk("stall_first_addr", rom_bus.addr, 32'hbfc0_000c);
        chk("stall_first_if", if_addr, 32'hbfc0_0008);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall_en%0d", i), {31'd0, rom_bus.en}, 32'd0);
            chk($sformatf("stall_if%0d", i), if_addr, 32'hbfc0_0008);
        end
        @(posedge clk);
        stall_force = 0;
        @(negedge clk);
        chk("stall_last_if", if_addr, 32'hbfc0_0008);
        @(negedge clk);
        chk("unstall_if", if_addr, 32'hbfc0_000c);
        chk("unstall_rom_addr", rom_bus.addr, 32'hbfc0_0010);
        repeat (5) @(posedge clk);
        exp_q = '{32'hbfc0_0000, 32'hbfc0_0004, 32'hbfc0_0008, 32'hbfc0_000c,
                  32'hbfc0_0010, 32'hbfc0_0014};
        check_seq("stall");

        // Reset in the middle of a 3-wait fetch at ...20 with stale ready in reset
        lat_k = 3;
        restart();
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (rom_bus.en && rom_bus.addr == 32'hbfc0_0020) found = 1;
        end
        chk("midrst_reached", {31'd0, found}, 32'd1);
        @(posedge clk);
        rst_k = 0;
        stray_pct = 100;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk);
        rst_k = 1;
        iss_q.delete();
        iss_cyc.delete();
        @(negedge clk);
        chk("midrst_ignore_stale", {31'd0, if_valid}, 32'd0);
        @(negedge clk);
        chk("midrst_first_en", {31'd0, rom_bus.en}, 32'd1);
        chk("midrst_first_addr", rom_bus.addr, 32'hbfc0_0000);
        stray_pct = 0;
        repeat (20) @(posedge clk);
        exp_q = '{32'hbfc0_0000, 32'hbfc0_0004};
        check_seq("midrst");

        // Randomized traffic: random latency, stalls, stray ready, branches
        lat_k = -1; stall_pct = 25; stray_pct = 30; br_mode = 2;
        restart();
        repeat (3000) @(posedge clk);
        chk("random_progress", {31'd0, iss_q.size() > 100}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
